dmem_rr_arbiter: RTL and testbench

//   Two-port round-robin arbiter that shares the single-port data memory (dmem)

---
 rtl/dmem_rr_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rr_arbiter.sv
// Two-port arbiter sharing a single-port data memory between the CPU/LSU (port 0)
// and the popcount engine (port 1); every access is grant -> memory cycle -> ack.
module dmem_rr_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

  state_t        state;
  logic          last;   // requester granted most recently
  logic          owner;  // requester whose access is in flight
  logic          is_rd;

  logic          grant;
  logic          win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;

  // NOTE: the grant must be visible in the same cycle the request is sampled, so
  // it is decoded combinationally; every signal gets a default to avoid latches.
  always_comb begin
    grant = (state == IDLE) && (req0 || req1);
    win   = 1'b0;
    if (req0 && req1)
      win = (FIXED_PRI != 0) ? 1'b0 : ~last;
    else
      win = req1;
    gnt0     = grant && !win;
    gnt1     = grant &&  win;
    sel_we   = win ? we1   : we0;
    sel_addr = win ? addr1 : addr0;
    sel_wd   = win ? wd1   : wd0;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last   <= 1'b1;
      owner  <= 1'b0;
      is_rd  <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      mem_we <= 1'b0;
      mem_a  <= '0;
      mem_wd <= '0;
      rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          mem_we <= 1'b0;
          if (grant) begin
            last   <= win;
            owner  <= win;
            is_rd  <= !sel_we;
            mem_we <= sel_we;
            mem_a  <= sel_addr & WORD_MASK;
            mem_wd <= sel_wd;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          // dmem sees mem_a/mem_we this cycle; a write commits at this edge
          mem_we <= 1'b0;
          if (is_rd)
            rdata <= mem_rd;
          ack0  <= !owner;
          ack1  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_gnt : assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_one_ack : assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed vector table, multi-cycle corner sequences,
// and random two-requester traffic checked against a transaction-level model.
module tb_dmem_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic        gnt0, gnt1, ack0, ack1, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic        f_req0, f_req1;
  logic        f_gnt0, f_gnt1, f_ack0, f_ack1, f_mem_we;
  logic [31:0] f_rdata, f_mem_a, f_mem_wd;
  logic [31:0] f_zero = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_rr_arbiter #(.AW(32), .DW(32), .FIXED_PRI(0)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_rr_arbiter #(.AW(32), .DW(32), .FIXED_PRI(1)) dut_fixed (
    .clk(clk), .reset(reset),
    .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
    .addr0(32'h10), .addr1(32'h14), .wd0(32'h0), .wd1(32'h0),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata),
    .mem_we(f_mem_we), .mem_a(f_mem_a), .mem_wd(f_mem_wd), .mem_rd(f_zero)
  );

  // dmem model: combinational read, posedge write, plus a bench-only preload port
  logic [31:0] dmem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) begin
    if (pl_en)
      dmem[pl_idx] <= pl_data;
    else if (mem_we)
      dmem[mem_a[7:2]] <= mem_wd;
  end

  logic [31:0] ref_mem [64];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      pl_en  = 1'b1;
      pl_idx = 6'(i);
      if (rnd)          pl_data = $urandom;
      else if (i == 4)  pl_data = 32'h0000_00FF;
      else if (i == 5)  pl_data = 32'h0000_A5A5;
      else              pl_data = 32'h1000_0000 + 32'(i);
      ref_mem[i] = pl_data;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
  endtask

  typedef struct {
    logic        req0, we0;
    logic [31:0] addr0, wd0;
    logic        req1, we1;
    logic [31:0] addr1, wd1;
    logic        gnt0, gnt1, ack0, ack1, mem_we;
    logic [31:0] mem_a, rdata;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic g0, logic g1, logic k0, logic k1, logic mw,
                              logic [31:0] ma, logic [31:0] rd);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wd0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wd1 = d1;
    v.gnt0 = g0; v.gnt1 = g1; v.ack0 = k0; v.ack1 = k1; v.mem_we = mw;
    v.mem_a = ma; v.rdata = rd;
    return v;
  endfunction

  vec_t vecs [13];

  // random-phase driver and model state
  logic        r_req [2];
  logic        r_we  [2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wd  [2];
  logic        saw_gnt[2];

  initial begin
    //                 r0 w0 addr0  wd0  r1 w1 addr1  wd1  g0 g1 k0 k1 we mem_a  rdata
    vecs[0]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 32'h00, 32'h0);
    vecs[1]  = mk(1, 0, 32'h10, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0, 0, 32'h00, 32'h0);
    vecs[2]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 32'h10, 32'h0);
    vecs[3]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 1, 0, 0, 32'h10, 32'hFF);
    vecs[4]  = mk(0, 0, 32'h00, 0, 1, 1, 32'h50, 5, 0, 1, 0, 0, 0, 32'h10, 32'hFF);
    vecs[5]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 1, 32'h50, 32'hFF);
    vecs[6]  = mk(0, 0, 32'h00, 0, 1, 0, 32'h50, 0, 0, 1, 0, 1, 0, 32'h50, 32'hFF);
    vecs[7]  = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 32'h50, 32'hFF);
    vecs[8]  = mk(1, 0, 32'h13, 0, 1, 0, 32'h14, 0, 1, 0, 0, 1, 0, 32'h50, 32'h5);
    vecs[9]  = mk(0, 0, 32'h00, 0, 1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 32'h10, 32'h5);
    vecs[10] = mk(0, 0, 32'h00, 0, 1, 0, 32'h14, 0, 0, 1, 1, 0, 0, 32'h10, 32'hFF);
    vecs[11] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 32'h14, 32'hFF);
    vecs[12] = mk(0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0, 0, 0, 1, 0, 32'h14, 32'hA5A5);

    reset = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    f_req0 = 1'b0; f_req1 = 1'b0;
    idle_inputs();
    preload(0);

    @(negedge clk);
    check1("rst gnt0", gnt0, 1'b0);
    check1("rst gnt1", gnt1, 1'b0);
    check1("rst ack0", ack0, 1'b0);
    check1("rst ack1", ack1, 1'b0);
    check1("rst mem_we", mem_we, 1'b0);
    check32("rst mem_a", mem_a, 32'h0);
    check32("rst mem_wd", mem_wd, 32'h0);
    check32("rst rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // directed vector table: read, write-then-read, tie, unaligned address
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      req0 = vecs[i].req0; we0 = vecs[i].we0; addr0 = vecs[i].addr0; wd0 = vecs[i].wd0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; addr1 = vecs[i].addr1; wd1 = vecs[i].wd1;
      @(negedge clk);
      check1($sformatf("v%0d gnt0", i), gnt0, vecs[i].gnt0);
      check1($sformatf("v%0d gnt1", i), gnt1, vecs[i].gnt1);
      check1($sformatf("v%0d ack0", i), ack0, vecs[i].ack0);
      check1($sformatf("v%0d ack1", i), ack1, vecs[i].ack1);
      check1($sformatf("v%0d mem_we", i), mem_we, vecs[i].mem_we);
      check32($sformatf("v%0d mem_a", i), mem_a, vecs[i].mem_a);
      check32($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
    end

    // round-robin with both requests held: grants alternate 0,1,0,1
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
      @(negedge clk);
      check1($sformatf("rr%0d gnt0", k), gnt0, k % 4 == 0);
      check1($sformatf("rr%0d gnt1", k), gnt1, k % 4 == 2);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check1("rr tail ack1", ack1, 1'b1);
    check32("rr tail rdata", rdata, 32'hA5A5);

    // fixed priority: requester 0 always wins, requester 1 waits until req0 drops
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      f_req0 = (k < 5);
      f_req1 = 1'b1;
      @(negedge clk);
      check1($sformatf("fp%0d gnt0", k), f_gnt0, (k % 2 == 0) && (k < 5));
      check1($sformatf("fp%0d gnt1", k), f_gnt1, k == 6);
    end
    @(posedge clk); #1;
    f_req1 = 1'b0;

    // reset during the ACCESS cycle of a read
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    check1("rstrd gnt0", gnt0, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check1("rstrd ack0", ack0, 1'b0);
    check1("rstrd ack1", ack1, 1'b0);
    check1("rstrd mem_we", mem_we, 1'b0);
    check32("rstrd mem_a", mem_a, 32'h0);
    check32("rstrd rdata", rdata, 32'h0);
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h14;
    @(negedge clk);
    check1("rstrd tie gnt0", gnt0, 1'b1);
    check1("rstrd tie gnt1", gnt1, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check1("rstrd tie ack0", ack0, 1'b1);
    check32("rstrd tie rdata", rdata, 32'hFF);

    // reset during the ACCESS cycle of a write: the write still lands
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wd1 = 32'hDEAD_0001;
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check1("rstwr ack1", ack1, 1'b0);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check1("rstwr ack0", ack0, 1'b1);
    check32("rstwr rdata", rdata, 32'hDEAD_0001);

    // random traffic against a transaction-level model
    reset = 1'b1;
    idle_inputs();
    preload(1);
    reset = 1'b0;
    begin
      bit          m_last = 1'b1;
      bit          pend = 1'b0;
      int          pend_t = 0;
      bit          p_owner = 1'b0, p_we = 1'b0;
      logic [31:0] p_addr = '0, p_wd = '0, p_data = '0;
      for (int i = 0; i < 2; i++) begin
        r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wd[i] = '0; saw_gnt[i] = 1'b0;
      end
      for (int t = 0; t < 800; t++) begin
        bit e_g0, e_g1, e_k0, e_k1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
          if (!r_req[i] || saw_gnt[i]) begin
            r_req[i]  = ($urandom_range(0, 2) != 0);
            r_we[i]   = $urandom_range(0, 1) == 1;
            r_addr[i] = 32'($urandom_range(0, 255));
            r_wd[i]   = $urandom;
          end
        end
        req0 = r_req[0]; we0 = r_we[0]; addr0 = r_addr[0]; wd0 = r_wd[0];
        req1 = r_req[1]; we1 = r_we[1]; addr1 = r_addr[1]; wd1 = r_wd[1];
        @(negedge clk);
        e_g0 = 1'b0; e_g1 = 1'b0; e_k0 = 1'b0; e_k1 = 1'b0;
        if (pend && t == pend_t + 1) begin
          check1($sformatf("rnd t%0d mem_we", t), mem_we, p_we);
          check32($sformatf("rnd t%0d mem_a", t), mem_a, p_addr & 32'hFFFF_FFFC);
          if (p_we)
            check32($sformatf("rnd t%0d mem_wd", t), mem_wd, p_wd);
        end else begin
          check1($sformatf("rnd t%0d mem_we idle", t), mem_we, 1'b0);
        end
        if (pend && t == pend_t + 2) begin
          e_k0 = !p_owner;
          e_k1 = p_owner;
          if (!p_we)
            check32($sformatf("rnd t%0d rdata", t), rdata, p_data);
          pend = 1'b0;
        end
        if (!pend && (r_req[0] || r_req[1])) begin
          bit w;
          w = (r_req[0] && r_req[1]) ? !m_last : r_req[1];
          e_g0 = !w;
          e_g1 = w;
          m_last  = w;
          pend    = 1'b1;
          pend_t  = t;
          p_owner = w;
          p_we    = r_we[w];
          p_addr  = r_addr[w];
          p_wd    = r_wd[w];
          if (p_we)
            ref_mem[p_addr[7:2]] = p_wd;
          else
            p_data = ref_mem[p_addr[7:2]];
        end
        check1($sformatf("rnd t%0d gnt0", t), gnt0, e_g0);
        check1($sformatf("rnd t%0d gnt1", t), gnt1, e_g1);
        check1($sformatf("rnd t%0d ack0", t), ack0, e_k0);
        check1($sformatf("rnd t%0d ack1", t), ack1, e_k1);
        saw_gnt[0] = gnt0;
        saw_gnt[1] = gnt1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
